// File: rtl/conv3x3_multi_ch.sv
// conv3x3_multi_ch: multi-channel 3x3 convolution, 9*CIN MACs then bias, saturate, optional ReLU,
// result on a valid/ready handshake with a one-cycle done pulse on acceptance.
module conv3x3_multi_ch #(
   parameter int CIN    = 3,
   parameter int PIX_W  = 8,
   parameter int W_W    = 8,
   parameter int BIAS_W = 16,
   parameter int ACC_W  = 24,
   parameter int OUT_W  = 16,
   parameter int CH_W   = (CIN > 1) ? $clog2(CIN) : 1,
   parameter int WA_W   = $clog2(9*CIN)
)(
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     i_conv_en,
   input  logic                     i_relu_en,
   input  logic                     i_valid_in,
   output logic                     o_busy,
   output logic [CH_W-1:0]          o_ch_idx,
   output logic [WA_W-1:0]          o_weight_addr,
   input  logic [9*PIX_W-1:0]       i_win_in,
   input  logic signed [W_W-1:0]    i_weight_in,
   input  logic signed [BIAS_W-1:0] i_bias,
   output logic                     o_valid_out,
   input  logic                     i_ready_out,
   output logic signed [OUT_W-1:0]  o_out,
   output logic                     o_done
);
   typedef enum logic [1:0] {S_IDLE, S_MAC, S_BIAS, S_HOLD} state_t;
   localparam logic signed [ACC_W:0]   SMAX    = (ACC_W+1)'((longint'(1) << (OUT_W-1)) - 1);
   localparam logic signed [ACC_W:0]   SMIN    = -SMAX - (ACC_W+1)'(1);
   localparam logic signed [OUT_W-1:0] OUT_MAX = {1'b0, {(OUT_W-1){1'b1}}};
   localparam logic signed [OUT_W-1:0] OUT_MIN = {1'b1, {(OUT_W-1){1'b0}}};
   state_t                    r_state, w_next;
   logic signed [ACC_W-1:0]   r_acc;
   logic [CH_W-1:0]           r_ch;
   logic [3:0]                r_tap;
   logic [WA_W-1:0]           r_wa;
   logic signed [BIAS_W-1:0]  r_bias;
   logic                      r_relu, r_busy, r_valid, r_done;
   logic signed [OUT_W-1:0]   r_out;
   logic                      w_last;
   logic [PIX_W-1:0]          w_pix;
   logic signed [ACC_W-1:0]   w_pix_x, w_wt_x, w_prod;
   logic signed [ACC_W:0]     w_sum;
   logic signed [OUT_W-1:0]   w_sat, w_res;
   assign w_last  = (r_ch == CH_W'(CIN-1)) && (r_tap == 4'd8);
   assign w_pix   = i_win_in[r_tap*PIX_W +: PIX_W];
   assign w_pix_x = $signed(ACC_W'(w_pix));
   assign w_wt_x  = ACC_W'(i_weight_in);
   assign w_prod  = w_pix_x * w_wt_x;
   assign w_sum   = (ACC_W+1)'(r_acc) + (ACC_W+1)'(r_bias);
   assign w_sat   = (w_sum > SMAX) ? OUT_MAX : (w_sum < SMIN) ? OUT_MIN : w_sum[OUT_W-1:0];
   assign w_res   = (r_relu && w_sat[OUT_W-1]) ? '0 : w_sat;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  w_next = (i_conv_en && i_valid_in) ? S_MAC : S_IDLE;
         S_MAC:   w_next = !i_conv_en ? S_IDLE : w_last ? S_BIAS : S_MAC;
         S_BIAS:  w_next = !i_conv_en ? S_IDLE : S_HOLD;
         default: w_next = (!i_conv_en || i_ready_out) ? S_IDLE : S_HOLD;
      endcase
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc   <= '0;
         r_ch    <= '0;
         r_tap   <= '0;
         r_wa    <= '0;
         r_bias  <= '0;
         r_relu  <= 1'b0;
         r_busy  <= 1'b0;
         r_valid <= 1'b0;
         r_done  <= 1'b0;
         r_out   <= '0;
      end else begin
         r_busy  <= w_next != S_IDLE;
         r_valid <= w_next == S_HOLD;
         r_done  <= r_state == S_HOLD && i_conv_en && i_ready_out;
         if (r_state == S_IDLE && w_next == S_MAC) begin
            r_bias <= i_bias;
            r_relu <= i_relu_en;
         end
         if (r_state == S_BIAS && i_conv_en) r_out <= w_res;
         // The BIAS edge consumes r_acc combinationally, so clearing on every non-MAC edge is safe.
         if (r_state == S_MAC && i_conv_en) begin
            r_acc <= r_acc + w_prod;
            r_tap <= (r_tap == 4'd8) ? 4'd0 : r_tap + 4'd1;
            r_ch  <= w_last ? '0 : (r_tap == 4'd8) ? r_ch + 1'b1 : r_ch;
            r_wa  <= w_last ? '0 : r_wa + 1'b1;
         end else begin
            r_acc <= '0;
            r_tap <= '0;
            r_ch  <= '0;
            r_wa  <= '0;
         end
      end
   end
   assign o_busy        = r_busy;
   assign o_ch_idx      = r_ch;
   assign o_weight_addr = r_wa;
   assign o_valid_out   = r_valid;
   assign o_out         = r_out;
   assign o_done        = r_done;
endmodule

// File: tb/tb_conv3x3_multi_ch.sv
// tb_conv3x3_multi_ch: directed and randomized checks of conv3x3_multi_ch against an arithmetic model
// of the dot product, bias, saturation and ReLU, plus handshake, abort and reset behaviour.
module tb_conv3x3_multi_ch;
   localparam int CIN = 3;
   localparam int N   = 9*CIN;
   logic              clk = 1'b0, rst_n = 1'b0;
   logic              i_conv_en = 1'b0, i_relu_en = 1'b0, i_valid_in = 1'b0, i_ready_out = 1'b0;
   logic              o_busy, o_valid_out, o_done;
   logic [1:0]        o_ch_idx;
   logic [4:0]        o_weight_addr;
   logic [71:0]       w_win;
   logic signed [7:0] w_wt;
   logic signed [15:0] i_bias = '0;
   logic signed [15:0] o_out;
   int                pix [CIN][9];
   int                wt  [N];
   int                n_chk = 0, n_err = 0;
   always #5 clk = ~clk;
   // Upstream window mux and combinational weight ROM.
   always_comb begin
      w_win = '0;
      for (int k = 0; k < 9; k++) w_win[k*8 +: 8] = (o_ch_idx < CIN) ? 8'(pix[o_ch_idx][k]) : 8'd0;
      w_wt = (o_weight_addr < N) ? 8'(wt[o_weight_addr]) : 8'sd0;
   end
   conv3x3_multi_ch #(.CIN(CIN)) dut (
      .clk(clk), .rst_n(rst_n), .i_conv_en(i_conv_en), .i_relu_en(i_relu_en), .i_valid_in(i_valid_in),
      .o_busy(o_busy), .o_ch_idx(o_ch_idx), .o_weight_addr(o_weight_addr), .i_win_in(w_win),
      .i_weight_in(w_wt), .i_bias(i_bias), .o_valid_out(o_valid_out), .i_ready_out(i_ready_out),
      .o_out(o_out), .o_done(o_done));
   task automatic chk(input string tag, input longint got, input longint exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   function automatic int model(input int b, input bit r);
      longint s = b;
      for (int c = 0; c < CIN; c++)
         for (int k = 0; k < 9; k++) s += longint'(pix[c][k]) * wt[c*9+k];
      s = (s > 32767) ? 32767 : (s < -32768) ? -32768 : s;
      return (r && s < 0) ? 0 : int'(s);
   endfunction
   task automatic fill(input int p, input int w);
      for (int c = 0; c < CIN; c++)
         for (int k = 0; k < 9; k++) begin
            pix[c][k] = p;
            wt[c*9+k] = w;
         end
   endtask
   // Full convolution: valid_in stays high throughout to show it is ignored outside IDLE.
   task automatic run_conv(input int b, input bit r, input int hold, input int exp);
      i_bias = 16'(b); i_relu_en = r; i_conv_en = 1'b1; i_valid_in = 1'b1; i_ready_out = (hold == 0);
      @(posedge clk); #1;
      i_bias = 16'($urandom); i_relu_en = ~r;
      chk("busy_start", o_busy, 1);
      for (int i = 0; i < N; i++) begin
         chk("weight_addr", o_weight_addr, i);
         chk("ch_idx", o_ch_idx, i/9);
         @(posedge clk); #1;
      end
      chk("addr_bias", o_weight_addr, 0);
      chk("valid_early", o_valid_out, 0);
      @(posedge clk); #1;
      chk("valid_latency", o_valid_out, 1);
      chk("out", o_out, exp);
      chk("done_early", o_done, 0);
      for (int h = 0; h < hold; h++) begin
         @(posedge clk); #1;
         chk("hold_valid", o_valid_out, 1);
         chk("hold_out", o_out, exp);
         chk("hold_done", o_done, 0);
      end
      i_ready_out = 1'b1;
      @(posedge clk); #1;
      i_valid_in = 1'b0; i_ready_out = 1'b0;
      chk("accept_valid", o_valid_out, 0);
      chk("accept_done", o_done, 1);
      chk("accept_busy", o_busy, 0);
      @(posedge clk); #1;
      chk("done_pulse", o_done, 0);
      chk("no_restart", o_busy, 0);
   endtask
   initial begin
      fill(0, 0);
      #2;
      chk("rst_busy", o_busy, 0);
      chk("rst_valid", o_valid_out, 0);
      chk("rst_out", o_out, 0);
      chk("rst_done", o_done, 0);
      chk("rst_addr", o_weight_addr, 0);
      chk("rst_ch", o_ch_idx, 0);
      #10 rst_n = 1'b1;
      @(posedge clk); #1;
      fill(1, 1);
      run_conv(0, 0, 0, 27);
      fill(0, 0);
      for (int k = 0; k < 9; k++) pix[0][k] = k + 1;
      for (int a = 0; a < N; a++) wt[a] = a;
      run_conv(-5, 0, 0, 235);
      fill(255, 127);
      run_conv(0, 0, 0, 32767);
      fill(255, -128);
      run_conv(0, 0, 0, -32768);
      run_conv(0, 1, 0, 0);
      fill(1, 1);
      run_conv(0, 0, 5, 27);
      i_conv_en = 1'b1; i_valid_in = 1'b1;
      @(posedge clk); #1;
      i_valid_in = 1'b0;
      repeat (4) @(posedge clk);
      #1 i_conv_en = 1'b0;
      @(posedge clk); #1;
      chk("abort_busy", o_busy, 0);
      chk("abort_valid", o_valid_out, 0);
      chk("abort_addr", o_weight_addr, 0);
      @(posedge clk); #1;
      chk("abort_done", o_done, 0);
      run_conv(0, 0, 0, 27);
      i_conv_en = 1'b1; i_valid_in = 1'b1;
      @(posedge clk); #1;
      repeat (5) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("mac_rst_busy", o_busy, 0);
      chk("mac_rst_addr", o_weight_addr, 0);
      chk("mac_rst_out", o_out, 0);
      i_valid_in = 1'b0;
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      run_conv(0, 0, 0, 27);
      fill(255, 127);
      i_conv_en = 1'b1; i_valid_in = 1'b1;
      @(posedge clk); #1;
      i_valid_in = 1'b0;
      repeat (N + 1) @(posedge clk);
      #1 chk("pre_rst_valid", o_valid_out, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("hold_rst_valid", o_valid_out, 0);
      chk("hold_rst_out", o_out, 0);
      chk("hold_rst_busy", o_busy, 0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      fill(1, 1);
      run_conv(0, 0, 0, 27);
      for (int t = 0; t < 8; t++) begin
         int b;
         bit r;
         for (int c = 0; c < CIN; c++)
            for (int k = 0; k < 9; k++) begin
               pix[c][k] = int'($urandom_range(0, 255));
               wt[c*9+k] = (t % 2) ? int'($urandom_range(0, 255)) - 128 : int'($urandom_range(0, 15)) - 8;
            end
         b = int'($urandom_range(0, 65535)) - 32768;
         r = 1'($urandom);
         run_conv(b, r, int'($urandom_range(0, 3)), model(b, r));
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
